fetch_ctrl: RTL

Fetch-stage sequencer for the RISC-V core: owns the architectural fetch PC register and decides each cycle whether the next PC is PC+4, a resolved branch/jump target, or a hold. It arbitrates redirect requests from execute against stall requests from hazard detection and instruction-memory back-pressure. It generates the select and hold controls for the next-PC mux, plus the decode-stage flush that squashes wrong-path instructions.

---
 rtl/fetch_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC and chooses PC+4, redirect target or hold each cycle,
// and generates the next-PC mux controls plus the decode flush for wrong-path squashing.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        pc_sel,
    output logic        stall,
    output logic        flush,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [2:0]  fcnt;
    logic [2:0]  fcnt_next;
    logic [31:0] pc_next;
    logic        misalign_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            fcnt     <= 3'd0;
            misalign <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            fcnt     <= fcnt_next;
            misalign <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        fcnt_next     = fcnt;
        misalign_next = misalign;
        fetch_valid   = 1'b0;
        pc_sel        = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;

        case (state)
            ST_BOOT: begin
                stall      = 1'b1;
                flush      = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN, ST_FLUSH: begin
                fetch_valid = 1'b1;
                flush       = (state == ST_FLUSH);
                // Redirect beats every hold source; the wrong-path count restarts on each one.
                if (redirect_valid) begin
                    pc_sel     = 1'b1;
                    flush      = 1'b1;
                    pc_next    = {redirect_target[31:2], 2'b00};
                    state_next = ST_FLUSH;
                    fcnt_next  = FLUSH_LOAD;
                    if (redirect_target[1:0] != 2'b00) begin
                        misalign_next = 1'b1;
                    end
                end else if (hazard_stall || !imem_ready) begin
                    stall = 1'b1;
                end else begin
                    pc_next = pc + 32'd4;
                    if (state == ST_FLUSH) begin
                        fcnt_next = fcnt - 3'd1;
                        if (fcnt <= 3'd1) begin
                            fcnt_next  = 3'd0;
                            state_next = ST_RUN;
                        end
                    end
                end
            end
            default: begin
                stall      = 1'b1;
                flush      = 1'b1;
                state_next = ST_BOOT;
            end
        endcase
    end

endmodule
